eth_tx_stream_adapter: RTL and testbench

- Upstream feeder for the Ethernet NAP transmit direction. Sits between user packet logic and the NAP Ethernet TX stream.
- Accepts an AXI-Stream-style packet bus with a bitwise byte-keep. Buffers it in an internal FIFO.
- Drives the NAP TX stream: numeric mod, sop/eop framing, per-packet TX flags, and a fixed EIU address.
- Checks keep legality and counts packets and errors.

---
 rtl/eth_tx_stream_adapter.sv | 213 +++++++++++++++++++++
 tb/tb_eth_tx_stream_adapter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_stream_adapter.sv
// eth_tx_stream_adapter
//   Feeds the Ethernet NAP transmit stream from a user AXI-Stream-style packet bus.
//   Beats are buffered in an internal FIFO. The beat at the head of the FIFO is then
//   loaded into a valid/ready output register. On the way out the adapter adds
//   sop/eop framing, a numeric mod, per-packet TX flags and a fixed EIU address.
//   It also checks keep legality and counts packets and keep errors.
//
// Build option:
//   ETH_TX_ADAPT_STORE_FWD_EN - store-and-forward. The output stage waits until a
//   whole packet is in the FIFO, or until the FIFO is full. Without the macro the
//   block is pure cut-through.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_tvalid/o_tready      user beat handshake (o_tready = FIFO not full)
//   i_tdata/i_tkeep        user data, bitwise byte-keep contiguous from bit 0
//   i_tlast/i_tuser        end of packet, force_error request
//   o_valid/i_ready        NAP TX handshake
//   o_data, o_sop, o_eop   NAP TX data and framing
//   o_mod                  valid-byte count on eop beats (0 = all 32 bytes)
//   o_addr                 EIU address (constant)
//   o_flags, o_timestamp   TX flag word; timestamp mirrors flags except on sop beats
//   o_pkt_cnt, o_err_cnt   packets sent (wraps), keep violations (saturates)
module eth_tx_stream_adapter #(
  parameter int         FIFO_DEPTH  = 64,
  parameter logic [3:0] EIU_ADDR    = 4'hf,
  parameter logic       CRC_INSERT  = 1'b1,
  parameter logic       EVENT_FRAME = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_tvalid,
  output logic         o_tready,
  input  logic [255:0] i_tdata,
  input  logic [31:0]  i_tkeep,
  input  logic         i_tlast,
  input  logic         i_tuser,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [255:0] o_data,
  output logic         o_sop,
  output logic         o_eop,
  output logic [4:0]   o_mod,
  output logic [3:0]   o_addr,
  output logic [29:0]  o_flags,
  output logic [29:0]  o_timestamp,
  output logic [31:0]  o_pkt_cnt,
  output logic [15:0]  o_err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {ST_SOP, ST_MID} state_t;

  // The wide data uses a RAM with a registered read straight into o_data. The narrow
  // metadata is read asynchronously, so that framing and flags can be decided in
  // the same cycle that the beat is loaded.
  logic [255:0] data_mem [FIFO_DEPTH];
  logic [6:0]   meta_mem [FIFO_DEPTH];  // {user, last, mod}

  logic [AW:0]  wr_ptr_reg, rd_ptr_reg, fill;
  logic         full, empty, wr_en, rd_en, src_ok, out_free, xfer, eop_xfer;
  logic [4:0]   keep_ones, in_mod, head_mod;
  logic [31:0]  keep_plus1;
  logic         keep_bad, head_last, head_user;
  logic [6:0]   head_meta;

  state_t       state_reg, state_next;
  logic [16:0]  id_reg, id_next, pkt_id_reg, pkt_id_next;
  logic         fe_reg, fe_next;
  logic         valid_next, sop_next, eop_next;
  logic [4:0]   mod_next;
  logic [29:0]  flags_next, ts_next;
  logic         o_valid_reg, o_sop_reg, o_eop_reg;
  logic [4:0]   o_mod_reg;
  logic [29:0]  o_flags_reg, o_ts_reg;
  logic [31:0]  pkt_cnt_reg;
  logic [15:0]  err_cnt_reg;
  logic [255:0] o_data_reg;

  assign fill     = wr_ptr_reg - rd_ptr_reg;
  assign full     = (fill == DEPTH_W);
  assign empty    = (fill == '0);
  assign o_tready = !full && !i_reset;
  assign wr_en    = i_tvalid && o_tready;

  // The 5-bit accumulator wraps, so a full keep (32 ones) gives mod 0.
  always_comb begin
    keep_ones = '0;
    for (int b = 0; b < 32; b++) keep_ones = keep_ones + {4'd0, i_tkeep[b]};
  end
  assign in_mod     = i_tlast ? keep_ones : 5'd0;
  // A keep that is contiguous from bit 0 is 2^n-1, so keep & (keep+1) is zero.
  assign keep_plus1 = i_tkeep + 32'd1;
  assign keep_bad   = (!i_tlast && (i_tkeep != '1)) ||
                      (i_tlast && (i_tkeep == '0)) ||
                      ((i_tkeep & keep_plus1) != '0);

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      data_mem[wr_ptr_reg[AW-1:0]] <= i_tdata;
      meta_mem[wr_ptr_reg[AW-1:0]] <= {i_tuser, i_tlast, in_mod};
    end
  end

  assign head_meta = meta_mem[rd_ptr_reg[AW-1:0]];
  assign head_mod  = head_meta[4:0];
  assign head_last = head_meta[5];
  assign head_user = head_meta[6];

  assign out_free = !o_valid_reg || i_ready;
  assign xfer     = o_valid_reg && i_ready;
  assign eop_xfer = xfer && o_eop_reg;
  assign rd_en    = out_free && !empty && src_ok;

`ifdef ETH_TX_ADAPT_STORE_FWD_EN
  // Counts the complete packets held in the FIFO. A full FIFO also releases data.
  // Without that, a packet longer than the FIFO could never drain.
  logic [AW:0] cmpl_cnt_reg, cmpl_cnt_next;
  assign src_ok = (cmpl_cnt_reg != '0) || full;
  always_comb begin
    cmpl_cnt_next = cmpl_cnt_reg;
    if (wr_en && i_tlast)  cmpl_cnt_next = cmpl_cnt_next + 1'b1;
    if (rd_en && head_last) cmpl_cnt_next = cmpl_cnt_next - 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) cmpl_cnt_reg <= '0;
    else         cmpl_cnt_reg <= cmpl_cnt_next;
  end
`else
  assign src_ok = 1'b1;
`endif

  // Framing FSM and output-register next values. The state moves on each load, so it
  // describes the next beat to enter the output register. A new sop can load in the
  // same edge that the previous eop transfers. For that reason the latched id comes
  // from id_next, which already includes this edge's increment.
  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    pkt_id_next = pkt_id_reg;
    fe_next     = fe_reg;
    valid_next  = o_valid_reg;
    sop_next    = o_sop_reg;
    eop_next    = o_eop_reg;
    mod_next    = o_mod_reg;
    flags_next  = o_flags_reg;
    ts_next     = o_ts_reg;
    if (eop_xfer) id_next = id_reg + 17'd1;
    if (rd_en) begin
      valid_next  = 1'b1;
      sop_next    = (state_reg == ST_SOP);
      eop_next    = head_last;
      mod_next    = head_last ? head_mod : 5'd0;
      fe_next     = sop_next ? head_user : (fe_reg || head_user);
      pkt_id_next = sop_next ? id_next : pkt_id_reg;
      flags_next  = {10'd0, CRC_INSERT, fe_next, EVENT_FRAME, pkt_id_next};
      ts_next     = sop_next ? 30'd0 : flags_next;
      state_next  = head_last ? ST_SOP : ST_MID;
    end else if (out_free) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      state_reg   <= ST_SOP;
      id_reg      <= '0;
      pkt_id_reg  <= '0;
      fe_reg      <= 1'b0;
      o_valid_reg <= 1'b0;
      o_sop_reg   <= 1'b0;
      o_eop_reg   <= 1'b0;
      o_mod_reg   <= '0;
      o_flags_reg <= '0;
      o_ts_reg    <= '0;
      pkt_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      state_reg   <= state_next;
      id_reg      <= id_next;
      pkt_id_reg  <= pkt_id_next;
      fe_reg      <= fe_next;
      o_valid_reg <= valid_next;
      o_sop_reg   <= sop_next;
      o_eop_reg   <= eop_next;
      o_mod_reg   <= mod_next;
      o_flags_reg <= flags_next;
      o_ts_reg    <= ts_next;
      if (eop_xfer) pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      if (wr_en && keep_bad && (err_cnt_reg != 16'hffff)) err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rd_en) o_data_reg <= data_mem[rd_ptr_reg[AW-1:0]];
  end

  assign o_valid     = o_valid_reg;
  assign o_data      = o_data_reg;
  assign o_sop       = o_sop_reg;
  assign o_eop       = o_eop_reg;
  assign o_mod       = o_mod_reg;
  assign o_addr      = EIU_ADDR;
  assign o_flags     = o_flags_reg;
  assign o_timestamp = o_ts_reg;
  assign o_pkt_cnt   = pkt_cnt_reg;
  assign o_err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_eth_tx_stream_adapter.sv
// Testbench for eth_tx_stream_adapter.
// Stimulus pushes the expected NAP beats into a queue. A monitor pops one beat from
// the queue on each NAP transfer and compares it with the outputs.
module tb_eth_tx_stream_adapter;
  logic         i_clk = 1'b0;
  logic         i_reset, i_tvalid, o_tready, i_tlast, i_tuser, o_valid, i_ready;
  logic [255:0] i_tdata, o_data;
  logic [31:0]  i_tkeep, o_pkt_cnt;
  logic         o_sop, o_eop;
  logic [4:0]   o_mod;
  logic [3:0]   o_addr;
  logic [29:0]  o_flags, o_timestamp;
  logic [15:0]  o_err_cnt;

  eth_tx_stream_adapter dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tvalid(i_tvalid), .o_tready(o_tready),
    .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast), .i_tuser(i_tuser),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sop(o_sop),
    .o_eop(o_eop), .o_mod(o_mod), .o_addr(o_addr), .o_flags(o_flags),
    .o_timestamp(o_timestamp), .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [4:0]   mod;
    logic [29:0]  flags;
  } beat_t;

  beat_t       sb[$];
  int          checks = 0;
  int          failures = 0;
  int          n_acc = 0;
  int          exp_pkt = 0;
  int          exp_err = 0;
  logic        tb_sop = 1'b1;
  logic        tb_fe = 1'b0;
  logic [16:0] tb_id = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input int tag);
    logic [31:0] t;
    t = 32'(tag) ^ 32'h5a000000;
    return {4{t, ~t}};
  endfunction

  // Call at posedge+1. The task returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l,
                      input logic u, input logic [4:0] emod, input logic bad);
    logic acc;
    int   waited;
    beat_t e;
    logic fe_m;
    i_tvalid = 1'b1; i_tdata = d; i_tkeep = k; i_tlast = l; i_tuser = u;
    acc = 1'b0; waited = 0;
    while (!acc && waited < 1000) begin
      @(negedge i_clk); acc = o_tready;
      @(posedge i_clk); #1; waited++;
    end
    i_tvalid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: got tready=0 for %0d cycles expected acceptance", waited);
    end else begin
      n_acc++;
      if (bad) exp_err++;
      fe_m = tb_sop ? u : (tb_fe | u);
      e.data = d; e.sop = tb_sop; e.eop = l; e.mod = emod;
      e.flags = {10'd0, 1'b1, fe_m, 1'b0, tb_id};
      sb.push_back(e);
      tb_fe = fe_m;
      if (l) begin tb_sop = 1'b1; tb_id = tb_id + 17'd1; end
      else tb_sop = 1'b0;
    end
  endtask

  task automatic align();
    @(posedge i_clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 2000) begin @(posedge i_clk); c++; end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
    idle(3);
  endtask

  // Monitor and scoreboard
  logic         stall_prev = 1'b0;
  logic [321:0] held;
  initial begin
    beat_t e;
    logic [29:0] ets;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        stall_prev = 1'b0;
      end else begin
        chk("pkt_cnt", 64'(o_pkt_cnt), 64'(exp_pkt));
        if (stall_prev) begin
          checks++;
          if (!o_valid || held !== {o_data, o_sop, o_eop, o_mod, o_flags, o_timestamp}) begin
            failures++;
            $display("FAIL stall_hold: got valid=%0b flags=%0h data=%0h, required the held beat flags=%0h",
                     o_valid, o_flags, o_data[31:0], held[59:30]);
          end
        end
        if (o_valid && i_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: got data=%0h with nothing expected", o_data[63:0]);
          end else begin
            e = sb.pop_front();
            ets = e.sop ? 30'd0 : e.flags;
            if (o_data !== e.data || o_sop !== e.sop || o_eop !== e.eop || o_mod !== e.mod ||
                o_flags !== e.flags || o_timestamp !== ets) begin
              failures++;
              $display("FAIL beat: got data=%0h sop=%0b eop=%0b mod=%0d flags=%0h ts=%0h expected data=%0h sop=%0b eop=%0b mod=%0d flags=%0h ts=%0h",
                       o_data[63:0], o_sop, o_eop, o_mod, o_flags, o_timestamp,
                       e.data[63:0], e.sop, e.eop, e.mod, e.flags, ets);
            end
          end
          if (o_eop) exp_pkt++;
        end
        stall_prev = o_valid && !i_ready;
        held = {o_data, o_sop, o_eop, o_mod, o_flags, o_timestamp};
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic seen;
    i_reset = 1'b1; i_tvalid = 1'b0; i_tdata = '0; i_tkeep = '0;
    i_tlast = 1'b0; i_tuser = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_tready", 64'(o_tready), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_sop_eop_mod", 64'({o_sop, o_eop, o_mod}), 64'd0);
    chk("rst_flags", 64'(o_flags), 64'd0);
    chk("rst_timestamp", 64'(o_timestamp), 64'd0);
    chk("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    chk("rst_err_cnt", 64'(o_err_cnt), 64'd0);
    chk("addr", 64'(o_addr), 64'hf);
    @(posedge i_clk); #1; i_reset = 1'b0;
    @(negedge i_clk);
    chk("tready_after_rst", 64'(o_tready), 64'd1);
    align();

    // Single 1-beat packet: o_valid rises two cycles after the beat is presented
    send(mk(1), 32'h0000000f, 1'b1, 1'b0, 5'd4, 1'b0);
    @(negedge i_clk); chk("lat_cycle1_valid", 64'(o_valid), 64'd0);
    @(negedge i_clk); chk("lat_cycle2_valid", 64'(o_valid), 64'd1);
    align();
    drain();
    chk("pkt_cnt_after_first", 64'(o_pkt_cnt), 64'd1);

    // 3-beat packet, full keep throughout
    send(mk(2), 32'hffffffff, 1'b0, 1'b0, 5'd0, 1'b0);
    send(mk(3), 32'hffffffff, 1'b0, 1'b0, 5'd0, 1'b0);
    send(mk(4), 32'hffffffff, 1'b1, 1'b0, 5'd0, 1'b0);
    drain();

    // Stall i_ready for 70 cycles while 100 beats are offered; 64 FIFO + 1 output beats fit
    base = n_acc;
    fork
      begin
        i_ready = 1'b0;
        repeat (70) @(posedge i_clk);
        #1; i_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 100; i++)
          send(mk(100 + i), (i % 4 == 3) ? 32'h000000ff : 32'hffffffff,
               (i % 4 == 3), 1'b0, (i % 4 == 3) ? 5'd8 : 5'd0, 1'b0);
      end
      begin
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
          @(negedge i_clk);
          if (!o_tready) seen = 1'b1;
        end
        chk("tready_fall_seen", 64'(seen), 64'd1);
        if (seen) chk("tready_fall_beats", 64'(n_acc - base), 64'd65);
      end
    join
    drain();

    // force_error raised on beat 2 of a 4-beat packet; the next packet is clean
    send(mk(300), 32'hffffffff, 1'b0, 1'b0, 5'd0, 1'b0);
    send(mk(301), 32'hffffffff, 1'b0, 1'b1, 5'd0, 1'b0);
    send(mk(302), 32'hffffffff, 1'b0, 1'b0, 5'd0, 1'b0);
    send(mk(303), 32'h000003ff, 1'b1, 1'b0, 5'd10, 1'b0);
    send(mk(304), 32'h7fffffff, 1'b1, 1'b0, 5'd31, 1'b0);
    send(mk(305), 32'h00000001, 1'b1, 1'b1, 5'd1, 1'b0);
    drain();

    // Keep violations: the beats are still forwarded
    chk("err_cnt_clean", 64'(o_err_cnt), 64'd0);
    send(mk(400), 32'h0000ffff, 1'b0, 1'b0, 5'd0, 1'b1);
    send(mk(401), 32'h00000005, 1'b1, 1'b0, 5'd2, 1'b1);
    idle(1);
    chk("err_cnt_two", 64'(o_err_cnt), 64'd2);
    send(mk(402), 32'h00000000, 1'b1, 1'b0, 5'd0, 1'b1);
    send(mk(403), 32'hfffffffe, 1'b0, 1'b0, 5'd0, 1'b1);
    send(mk(404), 32'h0000000f, 1'b1, 1'b0, 5'd4, 1'b0);
    drain();
    chk("err_cnt_total", 64'(o_err_cnt), 64'(exp_err));

`ifdef ETH_TX_ADAPT_STORE_FWD_EN
    // Store-and-forward: nothing is released until the last beat has been written
    for (int i = 0; i < 4; i++) begin
      send(mk(500 + i), (i == 3) ? 32'h00000fff : 32'hffffffff, (i == 3), 1'b0,
           (i == 3) ? 5'd12 : 5'd0, 1'b0);
      if (i < 3) begin
        repeat (10) @(negedge i_clk);
        chk("sf_gap_valid", 64'(o_valid), 64'd0);
        align();
      end
    end
    @(negedge i_clk); chk("sf_last_cycle1", 64'(o_valid), 64'd0);
    @(negedge i_clk); chk("sf_last_cycle2", 64'(o_valid), 64'd1);
    align();
    drain();
    // A packet longer than the FIFO is released only once the FIFO fills
    for (int i = 0; i < 64; i++) send(mk(600 + i), 32'hffffffff, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge i_clk); chk("sf_full_cycle1", 64'(o_valid), 64'd0);
    @(negedge i_clk); chk("sf_full_cycle2", 64'(o_valid), 64'd1);
    align();
    for (int i = 64; i < 70; i++) send(mk(600 + i), 32'hffffffff, 1'b0, 1'b0, 5'd0, 1'b0);
    send(mk(670), 32'h0000000f, 1'b1, 1'b0, 5'd4, 1'b0);
    drain();
`endif

    // Reset in the middle of a packet drops everything; the next beat is a sop with id 0
    i_ready = 1'b0;
    send(mk(700), 32'hffffffff, 1'b0, 1'b0, 5'd0, 1'b0);
    send(mk(701), 32'hffffffff, 1'b0, 1'b1, 5'd0, 1'b0);
    idle(2);
    i_reset = 1'b1;
    sb.delete();
    exp_pkt = 0; exp_err = 0; tb_sop = 1'b1; tb_fe = 1'b0; tb_id = '0;
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    chk("post_rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    chk("post_rst_valid", 64'(o_valid), 64'd0);
    align();
    send(mk(800), 32'h00000001, 1'b1, 1'b0, 5'd1, 1'b0);
    drain();
    chk("post_rst_pkt_one", 64'(o_pkt_cnt), 64'd1);
    chk("post_rst_err", 64'(o_err_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
